// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control pipeline.
//  - ALUOp operation-class encodings (4-bit).
//  - 6-bit ALU control codes, zero-extended by users when CTRL_W > 6.
//  - Sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_XORI  = 4'b0010;
  localparam logic [3:0] OP_SLTI  = 4'b0011;
  localparam logic [3:0] OP_ANDI  = 4'b0100;
  localparam logic [3:0] OP_ORI   = 4'b0101;
  localparam logic [3:0] OP_BZ    = 4'b0110;
  localparam logic [3:0] OP_BGTZ  = 4'b0111;
  localparam logic [3:0] OP_BLEZ  = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  localparam logic [5:0] CODE_NOP   = 6'b000000;
  localparam logic [5:0] CODE_ADD   = 6'b001000;
  localparam logic [5:0] CODE_XOR   = 6'b001110;
  localparam logic [5:0] CODE_SLT   = 6'b001010;
  localparam logic [5:0] CODE_AND   = 6'b001100;
  localparam logic [5:0] CODE_OR    = 6'b001101;
  localparam logic [5:0] CODE_BGEZ  = 6'b100001;
  localparam logic [5:0] CODE_BLTZ  = 6'b011011;
  localparam logic [5:0] CODE_BGTZ  = 6'b000111;
  localparam logic [5:0] CODE_BLEZ  = 6'b000110;
  localparam logic [5:0] CODE_BNE   = 6'b000101;
  localparam logic [5:0] CODE_BEQ   = 6'b000100;
  localparam logic [5:0] CODE_MUL   = 6'b000011;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } alu_ctrl_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/Funct/Rt0 -> ALU control code map.
// Ports:
//   alu_op_i  ALUOp operation class
//   funct_i   R-type funct field, passed through for OP_RTYPE
//   rt0_i     rt LSB, selects BGEZ vs BLTZ for OP_BZ
//   code_o    ALU control code (fixed codes zero-extended to CTRL_W)
//   legal_o   ALUOp is inside the decode map
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CTRL_W = 6
) (
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic [CTRL_W-1:0] funct_i,
  input  logic              rt0_i,
  output logic [CTRL_W-1:0] code_o,
  output logic              legal_o
);

  logic [5:0] fixed_code;
  logic       use_funct;

  always_comb begin
    fixed_code = CODE_NOP;
    use_funct  = 1'b0;
    legal_o    = 1'b1;
    case (alu_op_i)
      OP_W'(OP_RTYPE): use_funct  = 1'b1;
      OP_W'(OP_ADDI):  fixed_code = CODE_ADD;
      OP_W'(OP_XORI):  fixed_code = CODE_XOR;
      OP_W'(OP_SLTI):  fixed_code = CODE_SLT;
      OP_W'(OP_ANDI):  fixed_code = CODE_AND;
      OP_W'(OP_ORI):   fixed_code = CODE_OR;
      OP_W'(OP_BZ):    fixed_code = rt0_i ? CODE_BGEZ : CODE_BLTZ;
      OP_W'(OP_BGTZ):  fixed_code = CODE_BGTZ;
      OP_W'(OP_BLEZ):  fixed_code = CODE_BLEZ;
      OP_W'(OP_BNE):   fixed_code = CODE_BNE;
      OP_W'(OP_BEQ):   fixed_code = CODE_BEQ;
      OP_W'(OP_MUL):   fixed_code = CODE_MUL;
      default:         legal_o    = 1'b0;
    endcase
  end

  assign code_o = use_funct ? funct_i : CTRL_W'(fixed_code);

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control stage at the ID/EX boundary with valid/ready handshake,
// stall, flush and a multi-cycle multiply sequencer.
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   In_Valid/In_Ready   decode-side handshake
//   ALUOp, Funct, Rt0   instruction fields to decode
//   Stall               freeze output register and sequencer
//   Flush               kill in-flight instruction (wins over Stall and accept)
//   Out_Valid           ALUControl valid for EX
//   ALUControl          registered control code
//   Mul_Busy            multiply sequence in progress
//   Illegal_Op          sticky unknown-ALUOp flag (only with ALU_CTRL_ILLEGAL_EN)
// Optional feature macro: ALU_CTRL_ILLEGAL_EN.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 4,
  parameter int unsigned CTRL_W     = 6,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [OP_W-1:0]   ALUOp,
  input  logic [CTRL_W-1:0] Funct,
  input  logic              Rt0,
  input  logic              Stall,
  input  logic              Flush,
  output logic              Out_Valid,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              Mul_Busy
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic              Illegal_Op
`endif
);

  if (CTRL_W < 6) begin : g_ctrl_w_chk
    $error("alu_control_pipe: CTRL_W must be >= 6");
  end
  if (OP_W < 4) begin : g_op_w_chk
    $error("alu_control_pipe: OP_W must be >= 4");
  end
  if (MUL_CYCLES < 1) begin : g_mul_chk
    $error("alu_control_pipe: MUL_CYCLES must be >= 1");
  end

  localparam int unsigned CntW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam bit          MulSeq = (MUL_CYCLES > 1);

  alu_ctrl_state_e   state_q;
  logic [CntW-1:0]   cnt_q;
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              busy_q;

  logic [CTRL_W-1:0] dec_code;
  logic              dec_legal;
  logic              accept;
  logic              is_mul;

  alu_ctrl_decode #(
    .OP_W   (OP_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op_i (ALUOp),
    .funct_i  (Funct),
    .rt0_i    (Rt0),
    .code_o   (dec_code),
    .legal_o  (dec_legal)
  );

  assign In_Ready = Reset_n & ~Stall & (state_q == StIdle);
  // A flushed cycle never accepts, even though In_Ready may be high.
  assign accept   = In_Valid & In_Ready & ~Flush;
  assign is_mul   = (ALUOp == OP_W'(OP_MUL));

  // The accept cycle plus MUL_CYCLES-1 held cycles give MUL_CYCLES of ALU occupancy.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
    end else if (Flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      busy_q  <= 1'b0;
    end else if (!Stall) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_code;
            if (is_mul && MulSeq) begin
              state_q <= StMul;
              cnt_q   <= CntW'(MUL_CYCLES - 1);
              busy_q  <= 1'b1;
            end
          end else begin
            valid_q <= 1'b0;
          end
        end
        StMul: begin
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Out_Valid  = valid_q;
  assign ALUControl = ctrl_q;
  assign Mul_Busy   = busy_q;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic illegal_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      illegal_q <= 1'b0;
    end else if (accept && !dec_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign Illegal_Op = illegal_q;
`else
  logic unused_legal;
  assign unused_legal = dec_legal;
`endif

endmodule
